long_multiplier_pipelined: RTL and testbench

Parametrised, pipelined array (long) multiplier with a selectable signed/unsigned mode per operation.
- Accepts one operand pair per cycle through a valid/ready handshake.
- The row-adder array is split into STAGES register-separated slices.
- Supports downstream back-pressure.
- Sits in the integer datapath wherever a combinational array multiplier fails timing at the target frequency.

---
 rtl/long_multiplier_pkg.sv | 17 +
 rtl/long_multiplier_product_row.sv | 25 ++
 rtl/long_multiplier_pipelined.sv | 128 ++++++++++++
 tb/tb_long_multiplier_pipelined.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/long_multiplier_pkg.sv
// Shared constants and elaboration helpers for the pipelined long multiplier.
package long_multiplier_pkg;

  localparam int MIN_DATA_WIDTH = 4;
  localparam int MAX_DATA_WIDTH = 64;

  // The array has DATA_WIDTH adder rows (extended width minus one); spread them evenly.
  function automatic int rows_per_stage(input int data_width, input int stages);
    return (data_width + stages - 1) / stages;
  endfunction

  function automatic bit params_legal(input int data_width, input int stages);
    return (data_width >= MIN_DATA_WIDTH) && (data_width <= MAX_DATA_WIDTH) &&
           (stages >= 1) && (stages <= data_width);
  endfunction

endpackage

// File: rtl/long_multiplier_product_row.sv
// One adder row of the array: adds (or subtracts, for the sign row) the gated
// multiplicand to the running sum and retires the lowest product bit.
module long_multiplier_product_row #(
  parameter int WIDTH    = 9,
  parameter bit INVERT_A = 1'b0
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             b_bit_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             prod_bit_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // The sign row has negative weight: ~a plus a carry-in of one gives -a.
  assign addend = b_bit_i ? (INVERT_A ? ~a_i : a_i) : '0;
  assign sum    = {acc_i[WIDTH-1], acc_i} + {addend[WIDTH-1], addend} +
                  (WIDTH+1)'(INVERT_A && b_bit_i);

  assign prod_bit_o = sum[0];
  assign acc_o      = sum[WIDTH:1];

endmodule

// File: rtl/long_multiplier_pipelined.sv
// Pipelined signed/unsigned array multiplier with valid/ready on both sides
// and a single global stall; latency is STAGES cycles.
module long_multiplier_pipelined
  import long_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   operand_A_i,
  input  logic [DATA_WIDTH-1:0]   operand_B_i,
  input  logic                    signed_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [2*DATA_WIDTH-1:0] result_o
);

  localparam int WP   = DATA_WIDTH + 1;
  localparam int ROWS = rows_per_stage(DATA_WIDTH, STAGES);

  if (!params_legal(DATA_WIDTH, STAGES)) begin : g_illegal
    $fatal(1, "long_multiplier_pipelined: DATA_WIDTH/STAGES out of range");
  end

  // acc is the signed running sum above the retired bits; low holds retired bits.
  typedef struct packed {
    logic          valid;
    logic [WP-1:0] a;
    logic [WP-1:0] b;
    logic [WP-1:0] acc;
    logic [WP-1:0] low;
  } stage_rec_t;

  logic          advance;
  logic [WP-1:0] a_ext;
  logic [WP-1:0] b_ext;
  logic [WP-1:0] pp0;
  stage_rec_t    init_rec;
  stage_rec_t    out_q;
  logic          unused_out;

  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  assign a_ext = {signed_i & operand_A_i[DATA_WIDTH-1], operand_A_i};
  assign b_ext = {signed_i & operand_B_i[DATA_WIDTH-1], operand_B_i};
  assign pp0   = b_ext[0] ? a_ext : '0;

  // Row zero needs no adder: it is the first partial product, already shifted once.
  always_comb begin
    init_rec       = '0;
    init_rec.valid = valid_i;
    init_rec.a     = a_ext;
    init_rec.b     = b_ext;
    init_rec.acc   = {pp0[WP-1], pp0[WP-1:1]};
    init_rec.low   = {{(WP-1){1'b0}}, pp0[0]};
  end

  for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
    stage_rec_t stage_in;
    stage_rec_t stage_out;
    stage_rec_t stage_q;

    if (gs == 0) begin : g_src_in
      assign stage_in = init_rec;
    end else begin : g_src_prev
      assign stage_in = g_stage[gs-1].stage_q;
    end

    for (genvar gk = 0; gk < ROWS; gk++) begin : g_row
      localparam int ROW = gs * ROWS + 1 + gk;
      stage_rec_t rec_in;
      stage_rec_t rec_out;

      if (gk == 0) begin : g_first
        assign rec_in = stage_in;
      end else begin : g_chain
        assign rec_in = g_row[gk-1].rec_out;
      end

      if (ROW <= WP - 1) begin : g_adder
        logic [WP-1:0] acc_sum;
        logic          prod_bit;

        long_multiplier_product_row #(
          .WIDTH    (WP),
          .INVERT_A (ROW == WP - 1)
        ) u_row (
          .acc_i      (rec_in.acc),
          .a_i        (rec_in.a),
          .b_bit_i    (rec_in.b[ROW]),
          .acc_o      (acc_sum),
          .prod_bit_o (prod_bit)
        );

        always_comb begin
          rec_out     = rec_in;
          rec_out.acc = acc_sum;
          rec_out.low = rec_in.low | (WP'(prod_bit) << ROW);
        end
      end else begin : g_delay
        // Trailing slots of an over-partitioned array just carry the record along.
        assign rec_out = rec_in;
      end
    end

    assign stage_out = g_row[ROWS-1].rec_out;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        stage_q <= '0;
      end else if (advance) begin
        stage_q <= stage_out;
      end
    end
  end

  assign out_q    = g_stage[STAGES-1].stage_q;
  assign valid_o  = out_q.valid;
  assign result_o = {out_q.acc[WP-3:0], out_q.low};

  // Operand remnants and the top sum bits are dead once the last row has run.
  assign unused_out = ^{out_q.a, out_q.b, out_q.acc[WP-1:WP-2]};

endmodule

// File: tb/tb_long_multiplier_pipelined.sv
// Directed plus randomized bench for long_multiplier_pipelined with a
// queue-based reference model of products and arrival times.
module tb_long_multiplier_pipelined;

  localparam int DW = 8;
  localparam int ST = 2;
  localparam int PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          signed_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [DW-1:0] a_i = '0;
  logic [DW-1:0] b_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [PW-1:0] result_o;

  always #5 clk = ~clk;

  long_multiplier_pipelined #(
    .DATA_WIDTH (DW),
    .STAGES     (ST)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operand_A_i (a_i),
    .operand_B_i (b_i),
    .signed_i    (signed_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o)
  );

  typedef struct {
    logic [PW-1:0] prod;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cycle = 0;
  int            n_xfer = 0;
  bit            exact_lat = 1'b1;
  bit            prev_hold = 1'b0;
  logic [PW-1:0] prev_res = '0;

  function automatic logic [PW-1:0] ref_product(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b,
                                                input bit s);
    logic signed [PW-1:0] pa;
    logic signed [PW-1:0] pb;
    pa = s ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    pb = s ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    return PW'(pa * pb);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock cycle: drive, observe this cycle's outputs, then advance past the edge.
  task automatic step(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input bit s, input bit r);
    bit exp_valid;
    valid_i  = v;
    a_i      = a;
    b_i      = b;
    signed_i = s;
    ready_i  = r;
    #1;
    check("ready_o", 64'(ready_o), 64'(!valid_o || r));
    if (prev_hold) begin
      check("hold_valid", 64'(valid_o), 64'd1);
      check("hold_result", 64'(result_o), 64'(prev_res));
    end
    if (exact_lat) begin
      exp_valid = (sb.size() > 0) ? (sb[0].cyc + ST == cycle) : 1'b0;
      check("valid_o", 64'(valid_o), 64'(exp_valid));
    end
    if (valid_o && r) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result_o), 64'(e.prod));
        n_xfer++;
        $display("xfer %0d: result 0x%0h (accepted cycle %0d, out cycle %0d)",
                 n_xfer, result_o, e.cyc, cycle);
      end
    end
    prev_hold = valid_o && !r;
    prev_res  = result_o;
    if (v && ready_o) sb.push_back('{ref_product(a, b, s), cycle});
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [DW-1:0] corners [4];
    corners[0] = '0;
    corners[1] = '1;
    corners[2] = {1'b1, {(DW-1){1'b0}}};
    corners[3] = {1'b0, {(DW-1){1'b1}}};

    // Reset state
    #1;
    check("reset_valid_o", 64'(valid_o), 64'd0);
    check("reset_result_o", 64'(result_o), 64'd0);
    check("reset_ready_o", 64'(ready_o), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    idle(2);

    // Unsigned max*max, exact latency
    step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    idle(ST + 2);

    // Mixed signedness back-to-back
    step(1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 8'h01, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
    idle(ST + 2);

    // Back-pressure with two products in flight
    exact_lat = 1'b0;
    step(1'b1, 8'h7F, 8'h81, 1'b1, 1'b1);
    step(1'b1, 8'hC3, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    idle(ST + 4);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Bubble pattern 1,0,1
    exact_lat = 1'b1;
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b1);
    idle(ST + 2);

    // Reset with two operations in flight
    step(1'b1, 8'h55, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid_o", 64'(valid_o), 64'd0);
    check("midreset_result_o", 64'(result_o), 64'd0);
    sb.delete();
    prev_hold = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(ST + 3);

    // Randomized traffic with random back-pressure
    exact_lat = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : DW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : DW'($urandom);
      step(($urandom_range(0, 9) < 7), ra, rb, 1'($urandom), ($urandom_range(0, 9) < 6));
    end
    idle(ST + 4);
    check("random_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
